// File: rtl/quick_spi_slave.sv
// rtl/quick_spi_slave.sv - oversampling SPI responder for the quick_spi master (optional QUICK_SPI_SLAVE_ECHO_EN loopback)
module quick_spi_slave #(
    parameter int RX_DATA_WIDTH      = 16,
    parameter int TX_DATA_WIDTH      = 8,
    parameter bit CPOL               = 1'b0,
    parameter bit CPHA               = 1'b0,
    parameter int TURNAROUND_TOGGLES = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     sclk,
    input  logic                     mosi,
    input  logic                     ss_n,
    output logic                     miso,
    input  logic                     tx_arm,
    input  logic [TX_DATA_WIDTH-1:0] tx_data,
    output logic [RX_DATA_WIDTH-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     frame_done,
    output logic                     frame_error,
    output logic                     busy
);
    localparam int RX_END   = 2 * RX_DATA_WIDTH;
    localparam int TX_START = RX_END + TURNAROUND_TOGGLES;
    localparam int TX_END   = TX_START + 2 * TX_DATA_WIDTH;
    localparam int CNT_W    = $clog2(TX_END + 1);

    typedef enum logic [2:0] {IDLE, RECEIVE, TURNAROUND, TRANSMIT, TAIL} state_t;

    // Bit [2] of each chain is the previous synchronized value, used for edge detection.
    logic [2:0] sclk_sync_q;
    logic [2:0] ss_sync_q;
    logic [1:0] mosi_sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync_q <= {3{CPOL}};
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            ss_sync_q   <= {ss_sync_q[1:0], ss_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    logic sclk_edge, lead_edge, trail_edge, sample_edge, drive_edge, ss_fall, ss_rise, mosi_s;
    assign sclk_edge   = sclk_sync_q[2] ^ sclk_sync_q[1];
    assign lead_edge   = sclk_edge && (sclk_sync_q[1] != CPOL);
    assign trail_edge  = sclk_edge && (sclk_sync_q[1] == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = ss_sync_q[2] & ~ss_sync_q[1];
    assign ss_rise     = ~ss_sync_q[2] & ss_sync_q[1];
    assign mosi_s      = mosi_sync_q[1];

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [RX_DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [TX_DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic arm_q, arm_d, rx_done_q, rx_done_d, rx_valid_q, rx_valid_d;
    logic frame_done_q, frame_done_d, frame_error_q, frame_error_d;
    logic busy_q, busy_d, oe_q, oe_d, miso_q, miso_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cnt_inc       = cnt_q + 1'b1;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        tx_shift_d    = tx_shift_q;
        arm_d         = arm_q;
        rx_done_d     = rx_done_q;
        rx_valid_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        busy_d        = busy_q;
        oe_d          = oe_q;
        miso_d        = miso_q;
        case (state_q)
            IDLE: begin
                if (enable && ss_fall) begin
                    state_d    = RECEIVE;
                    cnt_d      = '0;
                    arm_d      = tx_arm;
                    tx_shift_d = tx_data;
                    rx_done_d  = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RECEIVE: begin
                if (sclk_edge) begin
                    cnt_d = cnt_inc;
                    if (sample_edge) rx_shift_d = {rx_shift_q[RX_DATA_WIDTH-2:0], mosi_s};
                    if (cnt_inc == CNT_W'(RX_END)) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        rx_done_d  = 1'b1;
`ifdef QUICK_SPI_SLAVE_ECHO_EN
                        tx_shift_d = rx_shift_d[TX_DATA_WIDTH-1:0];
`endif
                        if (!arm_q) begin
                            state_d = TAIL;
                        end else if (TURNAROUND_TOGGLES == 0) begin
                            state_d = TRANSMIT;
                            oe_d    = ~CPHA;
                            miso_d  = tx_shift_d[TX_DATA_WIDTH-1];
                        end else begin
                            state_d = TURNAROUND;
                        end
                    end
                end
            end
            TURNAROUND: begin
                if (sclk_edge) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TX_START)) begin
                        state_d = TRANSMIT;
                        oe_d    = ~CPHA;
                        miso_d  = tx_shift_q[TX_DATA_WIDTH-1];
                    end
                end
            end
            TRANSMIT: begin
                if (sclk_edge) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TX_END)) begin
                        state_d = TAIL;
                        oe_d    = 1'b0;
                    end else if (drive_edge) begin
                        // CPHA=1 presents the current MSB; CPHA=0 already showed it and moves on.
                        tx_shift_d = {tx_shift_q[TX_DATA_WIDTH-2:0], 1'b0};
                        miso_d     = CPHA ? tx_shift_q[TX_DATA_WIDTH-1] : tx_shift_d[TX_DATA_WIDTH-1];
                        oe_d       = 1'b1;
                    end
                end
            end
            TAIL: begin
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && ss_rise) begin
            state_d       = IDLE;
            oe_d          = 1'b0;
            busy_d        = 1'b0;
            frame_done_d  = rx_done_d;
            frame_error_d = ~rx_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            tx_shift_q    <= '0;
            arm_q         <= 1'b0;
            rx_done_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
            oe_q          <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            tx_shift_q    <= tx_shift_d;
            arm_q         <= arm_d;
            rx_done_q     <= rx_done_d;
            rx_valid_q    <= rx_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
            oe_q          <= oe_d;
            miso_q        <= miso_d;
        end
    end

    assign miso        = oe_q ? miso_q : 1'bz;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_quick_spi_slave.sv
// tb/tb_quick_spi_slave.sv - scoreboard bench for quick_spi_slave in modes 0 and 3
module tb_quick_spi_slave;
    localparam int H = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, enable, sclk, mosi, ss0_n, ss3_n, tx_arm;
    logic [7:0] tx_data;
    wire miso0u, miso0d, miso3;
    pullup (miso0u);
    pulldown (miso0d);
    pullup (miso3);

    logic [15:0] rx_data0u, rx_data0d, rx_data3;
    logic rx_valid0u, frame_done0u, frame_error0u, busy0u;
    logic rx_valid0d, frame_done0d, frame_error0d, busy0d;
    logic rx_valid3, frame_done3, frame_error3, busy3;

    quick_spi_slave dut0u (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sclk(sclk), .mosi(mosi), .ss_n(ss0_n),
        .miso(miso0u), .tx_arm(tx_arm), .tx_data(tx_data), .rx_data(rx_data0u), .rx_valid(rx_valid0u),
        .frame_done(frame_done0u), .frame_error(frame_error0u), .busy(busy0u)
    );
    quick_spi_slave dut0d (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sclk(sclk), .mosi(mosi), .ss_n(ss0_n),
        .miso(miso0d), .tx_arm(tx_arm), .tx_data(tx_data), .rx_data(rx_data0d), .rx_valid(rx_valid0d),
        .frame_done(frame_done0d), .frame_error(frame_error0d), .busy(busy0d)
    );
    quick_spi_slave #(.CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sclk(sclk), .mosi(mosi), .ss_n(ss3_n),
        .miso(miso3), .tx_arm(tx_arm), .tx_data(tx_data), .rx_data(rx_data3), .rx_valid(rx_valid3),
        .frame_done(frame_done3), .frame_error(frame_error3), .busy(busy3)
    );

    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [15:0] exp_rx0[$];
    logic [15:0] exp_rx3[$];
    logic [7:0]  exp_rd[$];
    int n_valid0 = 0, n_done0 = 0, n_err0 = 0, n_valid3 = 0;

    always @(negedge clk) begin
        if (rx_valid0u) begin
            n_valid0++;
            if (exp_rx0.size() == 0) check("rx0_unexpected", 32'(rx_data0u), 32'hffff_ffff);
            else check("rx0_data", 32'(rx_data0u), 32'(exp_rx0.pop_front()));
        end
        if (frame_done0u) n_done0++;
        if (frame_error0u) n_err0++;
        if (rx_valid3) begin
            n_valid3++;
            if (exp_rx3.size() == 0) check("rx3_unexpected", 32'(rx_data3), 32'hffff_ffff);
            else check("rx3_data", 32'(rx_data3), 32'(exp_rx3.pop_front()));
        end
    end

    task automatic run_frame(input bit m3, input logic [15:0] w, input int nedges, input int zlimit,
                             input bit exp_busy, output logic [7:0] rd, output bit early);
        bit cpol, cpha;
        cpol  = m3;
        cpha  = m3;
        rd    = 8'h00;
        early = 1'b0;
        sclk  = cpol;
        repeat (4) @(negedge clk);
        if (m3) ss3_n = 1'b0; else ss0_n = 1'b0;
        if (!cpha) mosi = w[15];
        repeat (H) @(negedge clk);
        for (int k = 1; k <= nedges; k++) begin
            if (!m3 && k <= zlimit && !(miso0u === 1'b1 && miso0d === 1'b0)) early = 1'b1;
            if (!m3 && k == 1) check("busy_mid", 32'(busy0u), 32'(exp_busy));
            if (k > 36 && k <= 52 && ((k % 2 == 1) != cpha)) rd = {rd[6:0], m3 ? miso3 : miso0u};
            if (cpha && (k % 2 == 1) && k < 32) mosi = w[15 - (k - 1) / 2];
            sclk = (k % 2 == 1) ? ~cpol : cpol;
            if (!cpha && (k % 2 == 0) && k < 32) mosi = w[15 - k / 2];
            repeat (H) @(negedge clk);
        end
        ss0_n = 1'b1;
        ss3_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        bit early;
        int v, d, e;
        reset_n = 1'b0; enable = 1'b1; sclk = 1'b0; mosi = 1'b0;
        ss0_n = 1'b1; ss3_n = 1'b1; tx_arm = 1'b0; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_rx_data", 32'(rx_data0u), 32'h0);
        check("rst_busy", 32'(busy0u), 32'h0);
        check("rst_pulses", {rx_valid0u, frame_done0u, frame_error0u}, 32'h0);
        check("rst_miso_z", {miso0u, miso0d}, 32'h2);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // reset in the middle of a frame after five bits
        ss0_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            mosi = k[1];
            sclk = ~sclk;
            repeat (H) @(negedge clk);
        end
        check("mid_busy_before_reset", 32'(busy0u), 32'h1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", 32'(busy0u), 32'h0);
        check("midrst_rx_data", 32'(rx_data0u), 32'h0);
        check("midrst_miso_z", {miso0u, miso0d}, 32'h2);
        ss0_n = 1'b1; sclk = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_pulses", 32'(n_valid0 + n_err0 + n_done0), 32'h0);

        exp_rx0.push_back(16'h1234);
        run_frame(1'b0, 16'h1234, 32, 32, 1'b1, rd, early);
        check("after_rst_valid", 32'(n_valid0), 32'h1);

        // write only, master adds extra toggles
        v = n_valid0; d = n_done0; e = n_err0;
        tx_arm = 1'b0;
        exp_rx0.push_back(16'hA5C3);
        run_frame(1'b0, 16'hA5C3, 38, 38, 1'b1, rd, early);
        check("wr_valid_once", 32'(n_valid0 - v), 32'h1);
        check("wr_done", 32'(n_done0 - d), 32'h1);
        check("wr_no_err", 32'(n_err0 - e), 32'h0);
        check("wr_miso_never_driven", 32'(early), 32'h0);
        check("wr_busy_end", 32'(busy0u), 32'h0);

        // read frame in mode 0
        v = n_valid0; d = n_done0;
        tx_arm = 1'b1; tx_data = 8'h3C;
        exp_rx0.push_back(16'h5A0F);
        exp_rd.push_back(8'h3C);
        run_frame(1'b0, 16'h5A0F, 52, 36, 1'b1, rd, early);
        check("rd0_data", 32'(rd), 32'(exp_rd.pop_front()));
        check("rd0_z_before_tx", 32'(early), 32'h0);
        check("rd0_z_after", {miso0u, miso0d}, 32'h2);
        check("rd0_done", 32'(n_done0 - d), 32'h1);

        // mode 3 instance
        tx_arm = 1'b1; tx_data = 8'h81;
        exp_rx3.push_back(16'h0F01);
        exp_rd.push_back(8'h81);
        run_frame(1'b1, 16'h0F01, 52, 0, 1'b1, rd, early);
        check("rd3_data", 32'(rd), 32'(exp_rd.pop_front()));
        check("rd3_busy_end", 32'(busy3), 32'h0);
        sclk = 1'b0;
        repeat (6) @(negedge clk);

        // abort after seven bits
        v = n_valid0; d = n_done0; e = n_err0;
        tx_arm = 1'b0;
        run_frame(1'b0, 16'hFFFF, 14, 14, 1'b1, rd, early);
        check("abort_err", 32'(n_err0 - e), 32'h1);
        check("abort_no_valid", 32'(n_valid0 - v), 32'h0);
        check("abort_no_done", 32'(n_done0 - d), 32'h0);
        check("abort_rx_kept", 32'(rx_data0u), 32'h5A0F);
        check("abort_busy", 32'(busy0u), 32'h0);

        // ss_n rises during TX: done, not error
        d = n_done0; e = n_err0;
        tx_arm = 1'b1; tx_data = 8'hC6;
        exp_rx0.push_back(16'h0001);
        run_frame(1'b0, 16'h0001, 40, 36, 1'b1, rd, early);
        check("trunc_done", 32'(n_done0 - d), 32'h1);
        check("trunc_no_err", 32'(n_err0 - e), 32'h0);
        check("trunc_miso_z", {miso0u, miso0d}, 32'h2);

        // ss_n already low when enable rises: no frame
        v = n_valid0; d = n_done0; e = n_err0;
        tx_arm = 1'b0;
        enable = 1'b0;
        ss0_n = 1'b0;
        repeat (6) @(negedge clk);
        enable = 1'b1;
        run_frame(1'b0, 16'hBEEF, 32, 32, 1'b0, rd, early);
        check("en_late_no_frame", 32'(n_valid0 - v + n_done0 - d + n_err0 - e), 32'h0);

`ifdef QUICK_SPI_SLAVE_ECHO_EN
        tx_arm = 1'b1; tx_data = 8'h00;
        exp_rx0.push_back(16'h12AB);
        exp_rd.push_back(8'hAB);
        run_frame(1'b0, 16'h12AB, 52, 36, 1'b1, rd, early);
        check("echo_data", 32'(rd), 32'(exp_rd.pop_front()));
`endif

        check("rx0_drained", 32'(exp_rx0.size()), 32'h0);
        check("rx3_count", 32'(n_valid3), 32'h1);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/quick_spi_slave.md
Name: quick_spi_slave

Overview:
SPI responder that pairs with the team's quick_spi master on the same four-wire bus (sclk, mosi, miso, ss_n). It runs in the system clk domain and oversamples the bus. It shifts in an RX_DATA_WIDTH command/data word from the master. When armed for a read, it shifts out a TX_DATA_WIDTH response after a fixed number of turnaround sclk toggles.

Parameters:
RX_DATA_WIDTH, 16, bits received from master per frame (matches master outgoing width)
TX_DATA_WIDTH, 8, bits returned to master on a read frame (matches master incoming width)
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge, drive on trailing; 1 = drive on leading, sample on trailing
TURNAROUND_TOGGLES, 4, sclk edges between end of RX phase and start of TX phase (even, >=0)

Ports:
clk  input  1  system clock; must be >= 4x sclk frequency
reset_n  input  1  synchronous, active-low reset
enable  input  1  0 = ignore bus, keep miso at z
sclk  input  1  SPI clock from master (asynchronous)
mosi  input  1  SPI data from master (asynchronous)
ss_n  input  1  slave select, active low (asynchronous)
miso  output  1  SPI data to master; 1'bz whenever not in TX phase
tx_arm  input  1  sampled at frame start: 1 = drive TX phase this frame
tx_data  input  TX_DATA_WIDTH  response word, latched at frame start
rx_data  output  RX_DATA_WIDTH  last received word, MSB first on wire
rx_valid  output  1  one-clk pulse when RX_DATA_WIDTH bits received
frame_done  output  1  one-clk pulse on ss_n rise after complete frame
frame_error  output  1  one-clk pulse on ss_n rise before RX phase completes
busy  output  1  high from frame start to return to IDLE

Behaviour:
- Reset: miso=z, rx_data=0, rx_valid=0, frame_done=0, frame_error=0, busy=0, edge counter 0, state IDLE. Reset overrides mid-frame; no pulses emitted.
- sclk, mosi, ss_n pass through 2-FF synchronizers; an sclk edge is detected on a change of the synchronized value. Bus-to-action latency is 3 clk.
- Leading edge = sclk leaving CPOL; trailing = returning to CPOL. edge_cnt counts every detected edge within a frame.
- States: IDLE, RECEIVE, TURNAROUND, TRANSMIT, TAIL.
- IDLE: when enable=1 and synced ss_n falls: latch tx_arm and tx_data into shift reg, edge_cnt=0, busy=1, go to RECEIVE. ss_n already low at enable rise does not start a frame.
- RECEIVE: on each sample edge, shift mosi into rx shift reg LSB. When edge_cnt reaches 2*RX_DATA_WIDTH: rx_data<=shift reg, rx_valid pulse (same clk). Then go to TURNAROUND if tx_arm latched, else TAIL.
- TURNAROUND: count TURNAROUND_TOGGLES edges; miso stays z. With TURNAROUND_TOGGLES=0, go straight to TRANSMIT.
- TRANSMIT: CPHA=0: drive tx MSB on the clk edge_cnt reaches 2*RX+TURNAROUND, then next bit on each trailing edge. CPHA=1: drive next bit on each leading edge. After 2*TX_DATA_WIDTH edges, hold last bit and go to TAIL.
- TAIL: ignore further edges (master extra toggles); miso=z.
- Synced ss_n rise in any non-IDLE state: miso=z, busy=0, state IDLE. frame_done pulses if RX completed, else frame_error. A rise in TURNAROUND/TRANSMIT is frame_done; the TX truncation is not flagged.
- enable falling mid-frame: finish the current frame; next frame is not accepted.
- rx_valid and frame_done never pulse in the same clk unless RX completes on the same clk ss_n rises; in that case both pulse.

Optional Feature:
QUICK_SPI_SLAVE_ECHO_EN: when defined, tx_arm=1 with tx_data ignored returns the low TX_DATA_WIDTH bits of the just-received word (loopback for board bring-up). The TX shift reg is loaded at RX completion instead of frame start. When undefined, tx_data latched at frame start is always used and no loopback mux exists.

Test Plan:
- Reset mid-frame after 5 RX bits -> all outputs at reset values, miso=z, no rx_valid/frame_error; next full frame received correctly.
- Mode 0, tx_arm=0, master writes 16'hA5C3 plus 6 extra toggles -> rx_data=16'hA5C3, single rx_valid, miso z throughout, frame_done at ss_n rise.
- Mode 0, tx_arm=1, tx_data=8'h3C, TURNAROUND_TOGGLES=4 -> master reads 8'h3C; miso z before edge 36 and after ss_n rise.
- CPOL=1, CPHA=1 instance, write 16'h0F01 / read tx_data=8'h81 -> rx_data=16'h0F01, master reads 8'h81.
- ss_n deasserted after 7 RX bits -> frame_error pulse, no rx_valid, rx_data unchanged, busy=0.
- ECHO_EN build, tx_arm=1, master sends 16'h12AB -> master reads 8'hAB.
